tlb_op_ctrl: RTL
================

Name: tlb_op_ctrl

Overview:
- Sequences the three TLB instructions: TLBP, TLBR and TLBWI.
- Issues the TLBP search from EX and holds it off while an EntryHi write (MTC0) is still in flight. Captures the probe result for CP0.
- For TLBR and TLBWI, generates the TLB read/write strobes at WB commit, then forces a pipeline flush and refetch from pc+4.
- Sits beside the WB stage/CP0 and drives the TLB s1 search port and TLB write port.

Parameters:
TLBNUM, 16, number of TLB entries
IDXW, 4, index width (log2 TLBNUM)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
es_valid  in  1  EX holds a valid instruction
es_tlb_op  in  2  EX op: 0 none, 1 TLBP, 2 TLBR, 3 TLBWI
es_pc  in  32  PC of EX instruction
es_fire  in  1  EX instruction moves to MEM this cycle
es_tlb_stall  out  1  hold EX (blocks es_fire)
ms_mtc0_entryhi  in  1  valid MTC0 to EntryHi in MEM
ws_mtc0_entryhi  in  1  valid MTC0 to EntryHi in WB
cp0_entryhi  in  32  current CP0 EntryHi
s1_vpn2  out  19  search VPN2 (= cp0_entryhi[31:13])
s1_asid  out  8  search ASID (= cp0_entryhi[7:0])
s1_found  in  1  search hit
s1_index  in  IDXW  hit index
tlbp_we  out  1  pulse: write probe result into CP0 Index
tlbp_found  out  1  probe hit (Index.P = ~tlbp_found)
tlbp_index  out  IDXW  probe index
ws_tlb_commit  in  1  WB commits the tracked TLB op (ws_valid, no exception)
ws_cancel  in  1  WB exception or ERET this cycle
tlb_we  out  1  pulse: TLBWI write strobe
tlbr_we  out  1  pulse: load CP0 EntryHi/Lo0/Lo1/PageMask from TLB
refetch  out  1  pulse: flush IF..WB, redirect fetch
refetch_pc  out  32  redirect target

Behaviour:
- Reset values:
  - state IDLE.
  - All pulse outputs 0.
  - tlbp_found 0, tlbp_index 0, refetch_pc 0, es_tlb_stall 0.
  - s1_vpn2/s1_asid are combinational from cp0_entryhi.
- States:
  - IDLE: no op in flight.
  - INFLIGHT: op accepted, waiting for WB commit. Registers op_r and pc_r.
  - REFETCH: one cycle.
- es_tlb_stall:
  - In IDLE, stall = es_valid & es_tlb_op==TLBP & (ms_mtc0_entryhi | ws_mtc0_entryhi).
  - In INFLIGHT or REFETCH, stall = es_valid & es_tlb_op!=0. Only one TLB op is in flight at a time.
- TLBP search:
  - Uses the s1 port combinationally in the EX cycle where stall=0 and es_fire=1.
  - s1_found/s1_index are registered into tlbp_found/tlbp_index on that edge.
- IDLE→INFLIGHT: on es_fire & es_tlb_op!=0. Latch op_r and pc_r.
- INFLIGHT, ws_cancel=1: go to IDLE with no pulses. Cancel has priority over commit in the same cycle.
- INFLIGHT, ws_tlb_commit=1:
  - TLBP: tlbp_we=1 (combinational this cycle), then IDLE.
  - TLBR: tlbr_we=1, then REFETCH.
  - TLBWI: tlb_we=1, then REFETCH.
- REFETCH:
  - refetch=1 for exactly one cycle, refetch_pc = pc_r + 4 (32-bit wrap, no carry out).
  - Then IDLE.
  - A concurrent ws_cancel has priority: refetch suppressed, go to IDLE.
- Latency: TLBWI/TLBR commit in cycle N gives refetch in cycle N+1.
- es_fire with es_tlb_op!=0 while stalled is a protocol violation; the bench asserts it never happens.
- reset mid-operation: returns to IDLE next edge; all pulses drop that cycle.

Test Plan:
- TLBP with EntryHi=0x1234_6005, TLB hit at index 7 → tlbp_index=7, tlbp_found=1. Commit → tlbp_we pulses 1 cycle, no refetch.
- MTC0 EntryHi in MEM, TLBP in EX → es_tlb_stall=1 for 2 cycles (MEM then WB). Search issues after the MTC0 leaves WB; result uses the new EntryHi.
- TLBWI at pc 0xBFC0_0100 commits → tlb_we=1 in cycle N; refetch=1, refetch_pc=0xBFC0_0104 in cycle N+1; state IDLE at N+2.
- TLBR then TLBWI back-to-back → second stalls in EX until REFETCH completes. tlbr_we and tlb_we each pulse once.
- TLBWI in flight, ws_cancel=1 together with ws_tlb_commit → no tlb_we, no refetch, state IDLE.
- reset asserted in REFETCH → refetch=0 that cycle; all outputs at reset values.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// ============================================================================
// Module   : tlb_op_ctrl
// Brief    : Sequences TLBP/TLBR/TLBWI: issues the probe, strobes the TLB at
//            WB commit and forces a refetch after TLBR/TLBWI.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            es_valid,
    input  logic [1:0]      es_tlb_op,
    input  logic [31:0]     es_pc,
    input  logic            es_fire,
    output logic            es_tlb_stall,
    input  logic            ms_mtc0_entryhi,
    input  logic            ws_mtc0_entryhi,
    input  logic [31:0]     cp0_entryhi,
    output logic [18:0]     s1_vpn2,
    output logic [7:0]      s1_asid,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_index,
    output logic            tlbp_we,
    output logic            tlbp_found,
    output logic [IDXW-1:0] tlbp_index,
    input  logic            ws_tlb_commit,
    input  logic            ws_cancel,
    output logic            tlb_we,
    output logic            tlbr_we,
    output logic            refetch,
    output logic [31:0]     refetch_pc
);

    localparam logic [1:0] c_OP_NONE  = 2'd0;
    localparam logic [1:0] c_OP_TLBP  = 2'd1;
    localparam logic [1:0] c_OP_TLBR  = 2'd2;
    localparam logic [1:0] c_OP_TLBWI = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INFLIGHT = 2'd1,
        S_REFETCH  = 2'd2
    } state_t;

    generate
        if (TLBNUM != (1 << IDXW)) begin : g_param_check
            $error("tlb_op_ctrl: TLBNUM must equal 2**IDXW");
        end
    endgenerate

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_op;
    logic [31:0] r_pc;
    logic        w_accept;
    logic        w_commit;
    logic        w_unused;

    assign s1_vpn2  = cp0_entryhi[31:13];
    assign s1_asid  = cp0_entryhi[7:0];
    assign w_unused = ^cp0_entryhi[12:8];

    // The probe must see the EntryHi value written by any older MTC0 still in MEM/WB.
    always_comb begin
        es_tlb_stall = 1'b0;
        if (r_state == S_IDLE) begin
            es_tlb_stall = es_valid & (es_tlb_op == c_OP_TLBP)
                         & (ms_mtc0_entryhi | ws_mtc0_entryhi);
        end else begin
            es_tlb_stall = es_valid & (es_tlb_op != c_OP_NONE);
        end
    end

    assign w_accept = (r_state == S_IDLE) & es_fire & (es_tlb_op != c_OP_NONE) & ~es_tlb_stall;
    assign w_commit = (r_state == S_INFLIGHT) & ws_tlb_commit & ~ws_cancel;

    always_comb begin
        w_state_nxt = r_state;
        tlbp_we     = 1'b0;
        tlb_we      = 1'b0;
        tlbr_we     = 1'b0;
        refetch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_INFLIGHT;
                end
            end
            S_INFLIGHT: begin
                if (ws_cancel) begin
                    w_state_nxt = S_IDLE;
                end else if (ws_tlb_commit) begin
                    case (r_op)
                        c_OP_TLBP: begin
                            tlbp_we     = 1'b1;
                            w_state_nxt = S_IDLE;
                        end
                        c_OP_TLBR: begin
                            tlbr_we     = 1'b1;
                            w_state_nxt = S_REFETCH;
                        end
                        c_OP_TLBWI: begin
                            tlb_we      = 1'b1;
                            w_state_nxt = S_REFETCH;
                        end
                        default: w_state_nxt = S_IDLE;
                    endcase
                end
            end
            S_REFETCH: begin
                refetch     = ~ws_cancel;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // Reset is synchronous, but strobes must not escape in the reset cycle.
        if (reset) begin
            tlbp_we = 1'b0;
            tlb_we  = 1'b0;
            tlbr_we = 1'b0;
            refetch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= c_OP_NONE;
            r_pc       <= 32'd0;
            tlbp_found <= 1'b0;
            tlbp_index <= '0;
            refetch_pc <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op <= es_tlb_op;
                r_pc <= es_pc;
                if (es_tlb_op == c_OP_TLBP) begin
                    tlbp_found <= s1_found;
                    tlbp_index <= s1_index;
                end
            end
            if (w_commit && (r_op != c_OP_TLBP)) begin
                refetch_pc <= r_pc + 32'd4;
            end
        end
    end

endmodule

`default_nettype wire
